wbconsole_fifo: RTL

CPU-side console peripheral that sits on the Wishbone slave bus and feeds the 7-bit console port of the debug-bus/console multiplexer. Characters written by software are buffered in a TX FIFO and handed to the multiplexer under its busy handshake. Characters the multiplexer extracts from the host stream are buffered in an RX FIFO for software to read. Status, overflow flags and interrupts are provided for a polling or interrupt-driven console driver.

---
 rtl/wbconsole_fifo.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/wbconsole_fifo.sv
// wbconsole_fifo
// Wishbone console peripheral: a TX FIFO feeds the 7-bit console port of the
// debug-bus/console multiplexer, and an RX FIFO buffers characters the
// multiplexer extracts from the host stream. STATUS reports fill counts and
// sticky overflow flags; interrupts flag RX data available and TX drained.
// LGFLEN is log2 of each FIFO depth and is meant to stay within 2..10 so the
// counts fit the 11-bit STATUS fields.

module wbconsole_fifo #(
  parameter int LGFLEN = 6
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic        i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_console_stb,
  output logic [6:0]  o_console_data,
  input  logic        i_console_busy,
  input  logic        i_console_stb,
  input  logic [6:0]  i_console_data,
  output logic        o_rx_int,
  output logic        o_tx_int
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN:0]   FULL_COUNT = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0]   COUNT_ONE  = {{LGFLEN{1'b0}}, 1'b1};
  localparam logic [LGFLEN:0]   COUNT_ZERO = {(LGFLEN + 1){1'b0}};
  localparam logic [LGFLEN-1:0] PTR_ONE    = {{(LGFLEN - 1){1'b0}}, 1'b1};
  localparam logic [LGFLEN-1:0] PTR_ZERO   = {LGFLEN{1'b0}};

  // Bus decode
  logic wb_req_s;
  logic wb_read_s;
  logic tx_push_req_s;
  logic rx_pop_req_s;
  logic tx_ovfl_clr_s;
  logic rx_ovfl_clr_s;

  // TX FIFO
  logic [6:0]        tx_mem_r [0:DEPTH-1];
  logic [LGFLEN-1:0] tx_wr_ptr_r;
  logic [LGFLEN-1:0] tx_rd_ptr_r;
  logic [LGFLEN-1:0] tx_rd_ptr_next_s;
  logic [LGFLEN:0]   tx_count_r;
  logic [LGFLEN:0]   tx_count_next_s;
  logic [6:0]        tx_head_next_s;
  logic              tx_full_s;
  logic              tx_empty_s;
  logic              tx_pop_s;
  logic              tx_push_ok_s;
  logic              tx_ovfl_set_s;
  logic              tx_ovfl_r;

  // RX FIFO
  logic [6:0]        rx_mem_r [0:DEPTH-1];
  logic [LGFLEN-1:0] rx_wr_ptr_r;
  logic [LGFLEN-1:0] rx_rd_ptr_r;
  logic [LGFLEN:0]   rx_count_r;
  logic [LGFLEN:0]   rx_count_next_s;
  logic              rx_full_s;
  logic              rx_empty_s;
  logic              rx_pop_s;
  logic              rx_push_ok_s;
  logic              rx_ovfl_set_s;
  logic              rx_ovfl_r;

  // Read path
  logic [10:0] tx_count_ext_s;
  logic [10:0] rx_count_ext_s;
  logic [31:0] status_s;
  logic [31:0] rdata_s;

  // Inputs that carry no meaning for this block
  logic unused_s;

  assign unused_s   = ^{i_wb_sel[2:1], i_wb_data[29:7]};
  assign o_wb_stall = 1'b0;

  assign wb_req_s      = i_wb_cyc && i_wb_stb;
  assign wb_read_s     = wb_req_s && !i_wb_we;
  assign tx_push_req_s = wb_req_s && i_wb_we && i_wb_addr && i_wb_sel[0];
  assign rx_pop_req_s  = wb_read_s && i_wb_addr;
  assign tx_ovfl_clr_s = wb_req_s && i_wb_we && !i_wb_addr && i_wb_sel[3] && i_wb_data[30];
  assign rx_ovfl_clr_s = wb_req_s && i_wb_we && !i_wb_addr && i_wb_sel[3] && i_wb_data[31];

  // Full/empty are judged on the count at cycle start. A pop can only happen
  // from a non-empty FIFO, and a pop on a full FIFO makes room for a push in
  // the same cycle.
  assign tx_full_s     = (tx_count_r == FULL_COUNT);
  assign tx_empty_s    = (tx_count_r == COUNT_ZERO);
  assign tx_pop_s      = !tx_empty_s && !i_console_busy;
  assign tx_push_ok_s  = tx_push_req_s && (!tx_full_s || tx_pop_s);
  assign tx_ovfl_set_s = tx_push_req_s && tx_full_s && !tx_pop_s;

  assign rx_full_s     = (rx_count_r == FULL_COUNT);
  assign rx_empty_s    = (rx_count_r == COUNT_ZERO);
  assign rx_pop_s      = rx_pop_req_s && !rx_empty_s;
  assign rx_push_ok_s  = i_console_stb && (!rx_full_s || rx_pop_s);
  assign rx_ovfl_set_s = i_console_stb && rx_full_s && !rx_pop_s;

  assign tx_rd_ptr_next_s = tx_pop_s ? (tx_rd_ptr_r + PTR_ONE) : tx_rd_ptr_r;

  assign tx_count_ext_s = 11'(tx_count_r);
  assign rx_count_ext_s = 11'(rx_count_r);
  assign status_s = {rx_ovfl_r, tx_ovfl_r, 3'b000, rx_count_ext_s, 5'b00000, tx_count_ext_s};

  // TX next count and the character that will sit at the head after this edge
  always_comb begin
    tx_count_next_s = tx_count_r;
    tx_head_next_s  = 7'h00;
    case ({tx_push_ok_s, tx_pop_s})
      2'b10:   tx_count_next_s = tx_count_r + COUNT_ONE;
      2'b01:   tx_count_next_s = tx_count_r - COUNT_ONE;
      default: tx_count_next_s = tx_count_r;
    endcase
    // The slot being written this cycle becomes the head when the FIFO is
    // empty afterwards-but-for-this-push; otherwise the head is already stored.
    if (tx_push_ok_s && (tx_wr_ptr_r == tx_rd_ptr_next_s)) begin
      tx_head_next_s = i_wb_data[6:0];
    end else begin
      tx_head_next_s = tx_mem_r[tx_rd_ptr_next_s];
    end
  end

  // RX next count
  always_comb begin
    rx_count_next_s = rx_count_r;
    case ({rx_push_ok_s, rx_pop_s})
      2'b10:   rx_count_next_s = rx_count_r + COUNT_ONE;
      2'b01:   rx_count_next_s = rx_count_r - COUNT_ONE;
      default: rx_count_next_s = rx_count_r;
    endcase
  end

  // Read mux: reflects state before any same-cycle push or pop
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (i_wb_addr) begin
      if (rx_empty_s) begin
        rdata_s = 32'h0000_0100;
      end else begin
        rdata_s = {25'h000_0000, rx_mem_r[rx_rd_ptr_r]};
      end
    end else begin
      rdata_s = status_s;
    end
  end

  // TX storage; entries need no reset because the count gates visibility
  always_ff @(posedge i_clk) begin
    if (tx_push_ok_s) begin
      tx_mem_r[tx_wr_ptr_r] <= i_wb_data[6:0];
    end
  end

  // RX storage; entries need no reset because the count gates visibility
  always_ff @(posedge i_clk) begin
    if (rx_push_ok_s) begin
      rx_mem_r[rx_wr_ptr_r] <= i_console_data;
    end
  end

  // TX pointers, count and registered console-side outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_wr_ptr_r    <= PTR_ZERO;
      tx_rd_ptr_r    <= PTR_ZERO;
      tx_count_r     <= COUNT_ZERO;
      o_console_stb  <= 1'b0;
      o_console_data <= 7'h00;
      o_tx_int       <= 1'b1;
    end else begin
      if (tx_push_ok_s) begin
        tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
      end
      tx_rd_ptr_r    <= tx_rd_ptr_next_s;
      tx_count_r     <= tx_count_next_s;
      o_console_stb  <= (tx_count_next_s != COUNT_ZERO);
      o_console_data <= tx_head_next_s;
      o_tx_int       <= (tx_count_next_s == COUNT_ZERO);
    end
  end

  // RX pointers, count and data-available interrupt
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_wr_ptr_r <= PTR_ZERO;
      rx_rd_ptr_r <= PTR_ZERO;
      rx_count_r  <= COUNT_ZERO;
      o_rx_int    <= 1'b0;
    end else begin
      if (rx_push_ok_s) begin
        rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
      end
      if (rx_pop_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
      end
      rx_count_r <= rx_count_next_s;
      o_rx_int   <= (rx_count_next_s != COUNT_ZERO);
    end
  end

  // Sticky overflow flags; a set in the same cycle as a clear wins
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_ovfl_r <= 1'b0;
      rx_ovfl_r <= 1'b0;
    end else begin
      tx_ovfl_r <= tx_ovfl_set_s || (tx_ovfl_r && !tx_ovfl_clr_s);
      rx_ovfl_r <= rx_ovfl_set_s || (rx_ovfl_r && !rx_ovfl_clr_s);
    end
  end

  // Bus response: ack every request one cycle later, capture read data
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= 32'h0000_0000;
    end else begin
      o_wb_ack <= wb_req_s;
      if (wb_read_s) begin
        o_wb_data <= rdata_s;
      end
    end
  end

endmodule
